// File: rtl/conv_window_engine_if.sv
// conv_window_engine_if: pixel stream, weight-write and filtered-output
// signals of the 3x3 convolution engine. The master drives the stream and
// the weight writes; the engine (slave) drives the filtered result.
interface conv_window_engine_if #(
    parameter int PIX_W = 4,
    parameter int WGT_W = 5
);
    logic [PIX_W-1:0]        pix_in;
    logic                    pix_valid;
    logic                    frame_start;
    logic                    wt_we;
    logic [3:0]              wt_addr;
    logic signed [WGT_W-1:0] wt_data;
    logic [PIX_W-1:0]        pix_out;
    logic                    out_valid;
    logic                    out_border;

    modport master (
        output pix_in, pix_valid, frame_start, wt_we, wt_addr, wt_data,
        input  pix_out, out_valid, out_border
    );

    modport slave (
        input  pix_in, pix_valid, frame_start, wt_we, wt_addr, wt_data,
        output pix_out, out_valid, out_border
    );
endinterface

// File: rtl/conv_window_engine.sv
// conv_window_engine: streaming 3x3 convolution over a raster image.
// Two line buffers and a 3x3 window advance only on accepted pixels; the
// result leaves two clock edges after the accepting edge. Centres on the
// image border (or before the first full window) produce forced zeros.
// Weights are double-buffered: writes land in a shadow bank that is copied
// to the active bank when a frame_start pixel is accepted.
// Optional feature: define CONV_ABS_EN to take the magnitude of the
// shifted sum before clamping (edge-magnitude output).
module conv_window_engine #(
    parameter int PIX_W = 4,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int WGT_W = 5,
    parameter int SHIFT = 0
) (
    input  logic                clk,
    input  logic                rst,
    conv_window_engine_if.slave bus
);
    localparam int ACC_W = PIX_W + WGT_W + 4;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    localparam logic [CW-1:0]           COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]           ROW_LAST = RW'(IMG_H - 1);
    localparam logic [PIX_W-1:0]        PIX_MAX  = '1;
    localparam logic signed [WGT_W-1:0] W_CENTRE = WGT_W'(8);
    localparam logic signed [WGT_W-1:0] W_EDGE   = '1;

    // One signed product term: weight sign-extended, pixel zero-extended.
    function automatic logic signed [ACC_W-1:0] mac_term(
        input logic signed [WGT_W-1:0] w,
        input logic [PIX_W-1:0]        p
    );
        logic signed [ACC_W-1:0] we;
        logic signed [ACC_W-1:0] pe;
        we = ACC_W'(w);
        pe = $signed(ACC_W'(p));
        return we * pe;
    endfunction

    // Arithmetic shift, optional magnitude, then clamp into the pixel range.
    function automatic logic [PIX_W-1:0] shift_clamp(
        input logic signed [ACC_W-1:0] s
    );
        logic signed [ACC_W-1:0] v;
        v = s >>> SHIFT;
`ifdef CONV_ABS_EN
        if (v[ACC_W-1]) v = -v;
`endif
        if (v[ACC_W-1]) return '0;
        if (v > $signed(ACC_W'(PIX_MAX))) return PIX_MAX;
        return v[PIX_W-1:0];
    endfunction

    logic                    accept;
    logic                    fs_accept;
    logic [CW-1:0]           col_cnt;
    logic [CW-1:0]           cur_col;
    logic [RW-1:0]           row_cnt;
    logic [RW-1:0]           cur_row;
    logic [PIX_W-1:0]        lb1 [IMG_W];
    logic [PIX_W-1:0]        lb2 [IMG_W];
    logic [PIX_W-1:0]        win_p0 [9];
    logic signed [WGT_W-1:0] wt_shadow [9];
    logic signed [WGT_W-1:0] wt_active [9];
    logic                    vld_p0;
    logic                    border_p0;
    logic signed [ACC_W-1:0] sum_p0;
    logic                    vld_p1;
    logic                    border_p1;
    logic signed [ACC_W-1:0] acc_p1;

    assign accept    = bus.pix_valid;
    assign fs_accept = bus.pix_valid & bus.frame_start;
    // Position of the pixel being accepted; frame_start overrides the count.
    assign cur_col   = fs_accept ? '0 : col_cnt;
    assign cur_row   = fs_accept ? '0 : row_cnt;

    // Raster position counters, pointing at the next pixel expected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_cnt <= cur_col + 1'b1;
                row_cnt <= cur_row;
            end
        end
    end

    // Line buffers: lb1 tail is one row back, lb2 tail two rows back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb1[i] <= '0;
                lb2[i] <= '0;
            end
        end else if (accept) begin
            lb1[0] <= bus.pix_in;
            lb2[0] <= lb1[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                lb1[i] <= lb1[i-1];
                lb2[i] <= lb2[i-1];
            end
        end
    end

    // ---- stage p0: window shift; newest pixel enters bottom-right ----
    // 3x3 window, index 0 top-left .. 8 bottom-right, centre at index 4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) win_p0[i] <= '0;
        end else if (accept) begin
            win_p0[0] <= win_p0[1];
            win_p0[1] <= win_p0[2];
            win_p0[2] <= lb2[IMG_W-1];
            win_p0[3] <= win_p0[4];
            win_p0[4] <= win_p0[5];
            win_p0[5] <= lb1[IMG_W-1];
            win_p0[6] <= win_p0[7];
            win_p0[7] <= win_p0[8];
            win_p0[8] <= bus.pix_in;
        end
    end

    // Stage p0 control. The centre trails the input by one row and one
    // column, so it is interior exactly when the input sits at col>=2 and
    // row>=2 (row IMG_H-1 as input puts the centre at IMG_H-2, still inside).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0    <= 1'b0;
            border_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept;
            if (accept) border_p0 <= !((cur_col >= CW'(2)) && (cur_row >= RW'(2)));
        end
    end

    // Shadow/active weight banks; active only changes at frame_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) begin
                wt_shadow[i] <= (i == 4) ? W_CENTRE : W_EDGE;
                wt_active[i] <= (i == 4) ? W_CENTRE : W_EDGE;
            end
        end else begin
            if (bus.wt_we && (bus.wt_addr < 4'd9)) wt_shadow[bus.wt_addr] <= bus.wt_data;
            if (fs_accept) begin
                for (int i = 0; i < 9; i++) wt_active[i] <= wt_shadow[i];
            end
        end
    end

    // Multiply-accumulate over the current window with the active weights.
    always_comb begin
        sum_p0 = '0;
        for (int i = 0; i < 9; i++) sum_p0 = sum_p0 + mac_term(wt_active[i], win_p0[i]);
    end

    // ---- stage p1: registered accumulator ----
    // Pipeline valid and border flag for the accumulator stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1    <= 1'b0;
            border_p1 <= 1'b0;
        end else begin
            vld_p1    <= vld_p0;
            border_p1 <= border_p0;
        end
    end

    // Accumulator register; qualified by vld_p1 downstream, so no reset.
    always_ff @(posedge clk) begin
        if (vld_p0) acc_p1 <= sum_p0;
    end

    // ---- stage p2: shift/clamp and output register ----
    // Output register; pix_out holds its last value between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_border <= 1'b0;
            bus.pix_out    <= '0;
        end else begin
            bus.out_valid <= vld_p1;
            if (vld_p1) begin
                bus.out_border <= border_p1;
                bus.pix_out    <= border_p1 ? '0 : shift_clamp(acc_p1);
            end
        end
    end
endmodule

// File: tb/tb_conv_window_engine.sv
// tb_conv_window_engine: directed table-driven bench for conv_window_engine
// on an 8x6 image with 4-bit pixels. A negedge monitor captures each output
// of the current frame and checks its two-edge latency.
module tb_conv_window_engine;
    localparam int PIX_W = 4;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int WGT_W = 5;
    localparam int SHIFT = 0;
    localparam int NPIX  = IMG_W * IMG_H;
`ifdef CONV_ABS_EN
    localparam int NB = 15;
`else
    localparam int NB = 0;
`endif

    typedef struct {
        int due;
        bit fs;
    } pend_t;

    typedef struct {
        int id;
        int k;
        int pix;
        int bdr;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    pend_t pend[$];
    pend_t mon_p;
    vec_t  vecs[$];
    int    cap_pix [64];
    int    cap_bdr [64];
    int    cap_n = 0;
    int    ref_pix [NPIX];
    int    ref_bdr [NPIX];

    conv_window_engine_if #(.PIX_W(PIX_W), .WGT_W(WGT_W)) bus();

    conv_window_engine #(
        .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .WGT_W(WGT_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: match each out_valid with its input and capture the frame.
    always @(negedge clk) begin
        if (!rst) begin
            pend.delete();
        end else begin
            if (bus.out_valid) begin
                if (pend.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    mon_p = pend.pop_front();
                    check("latency", cyc, mon_p.due);
                    if (mon_p.fs) cap_n = 0;
                    if (cap_n < 64) begin
                        cap_pix[cap_n] = int'(bus.pix_out);
                        cap_bdr[cap_n] = int'(bus.out_border);
                    end
                    cap_n++;
                end
            end
            if (bus.pix_valid) pend.push_back('{cyc + 3, bus.frame_start});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] pat_pix(input int pat, input int i);
        case (pat)
            0:       return 4'd7;
            1:       return (i == 27) ? 4'd15 : 4'd0;
            default: return 4'(((i / IMG_W) + (i % IMG_W)) & 15);
        endcase
    endfunction

    // Sends pixels first..last-1 of a pattern; pixel 0 carries frame_start.
    task automatic send_frame(input int pat, input int first, input int last, input int maxgap);
        for (int i = first; i < last; i++) begin
            if (maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
            bus.pix_in      = pat_pix(pat, i);
            bus.pix_valid   = 1'b1;
            bus.frame_start = (i == 0);
            @(posedge clk);
            #1;
            bus.pix_valid   = 1'b0;
            bus.frame_start = 1'b0;
            bus.wt_we       = 1'b0;
        end
    endtask

    task automatic write_wt(input int addr, input int val);
        bus.wt_we   = 1'b1;
        bus.wt_addr = 4'(addr);
        bus.wt_data = WGT_W'(val);
        @(posedge clk);
        #1;
        bus.wt_we   = 1'b0;
    endtask

    task automatic check_frame(input int id, input int n);
        check($sformatf("count_id%0d", id), cap_n, n);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].id == id) begin
                check($sformatf("pix_id%0d_k%0d", id, vecs[i].k), cap_pix[vecs[i].k], vecs[i].pix);
                check($sformatf("bdr_id%0d_k%0d", id, vecs[i].k), cap_bdr[vecs[i].k], vecs[i].bdr);
            end
        end
    endtask

    initial begin
        int s;
        int c;
        int exp_pix;
        int exp_bdr;
        bus.pix_in      = '0;
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.wt_we       = 1'b0;
        bus.wt_addr     = '0;
        bus.wt_data     = '0;

        // id 0: edge kernel, flat 7
        vecs.push_back('{0, 0, 0, 1});   vecs.push_back('{0, 8, 0, 1});
        vecs.push_back('{0, 18, 0, 0});  vecs.push_back('{0, 30, 0, 0});
        vecs.push_back('{0, 47, 0, 0});
        // id 1: edge kernel, single 15 at (3,3)
        vecs.push_back('{1, 36, 15, 0}); vecs.push_back('{1, 35, NB, 0});
        vecs.push_back('{1, 37, NB, 0}); vecs.push_back('{1, 28, NB, 0});
        vecs.push_back('{1, 44, NB, 0}); vecs.push_back('{1, 27, NB, 0});
        vecs.push_back('{1, 46, 0, 0});  vecs.push_back('{1, 20, 0, 0});
        // id 2: identity kernel, ramp
        vecs.push_back('{2, 0, 0, 1});   vecs.push_back('{2, 8, 0, 1});
        vecs.push_back('{2, 9, 0, 1});   vecs.push_back('{2, 18, 2, 0});
        vecs.push_back('{2, 20, 4, 0});  vecs.push_back('{2, 24, 0, 1});
        vecs.push_back('{2, 25, 0, 1});  vecs.push_back('{2, 30, 7, 0});
        vecs.push_back('{2, 47, 10, 0});
        // id 3: w4=2 written mid-frame, frame stays identity
        vecs.push_back('{3, 18, 2, 0});  vecs.push_back('{3, 30, 7, 0});
        vecs.push_back('{3, 47, 10, 0}); vecs.push_back('{3, 24, 0, 1});
        // id 4: w4=2 active (w4=3 written with this frame_start)
        vecs.push_back('{4, 18, 4, 0});  vecs.push_back('{4, 20, 8, 0});
        vecs.push_back('{4, 30, 14, 0}); vecs.push_back('{4, 47, 15, 0});
        vecs.push_back('{4, 9, 0, 1});
        // id 5: w4=3 active
        vecs.push_back('{5, 18, 6, 0});  vecs.push_back('{5, 20, 12, 0});
        vecs.push_back('{5, 30, 15, 0}); vecs.push_back('{5, 25, 0, 1});
        // id 6: frame restarted early at row 2
        vecs.push_back('{6, 18, 6, 0});  vecs.push_back('{6, 47, 15, 0});
        vecs.push_back('{6, 25, 0, 1});
        // id 7: single pixel after mid-frame reset, edge kernel again
        vecs.push_back('{7, 36, 15, 0}); vecs.push_back('{7, 35, NB, 0});
        vecs.push_back('{7, 28, NB, 0}); vecs.push_back('{7, 46, 0, 0});

        idle(3);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_pix_out", int'(bus.pix_out), 0);
        check("reset_out_border", int'(bus.out_border), 0);
        rst = 1'b1;
        idle(2);

        send_frame(0, 0, NPIX, 0);
        idle(4);
        check_frame(0, NPIX);
        s = 0;
        for (int k = 0; k < NPIX; k++) s += cap_pix[k];
        check("flat_sum", s, 0);

        send_frame(1, 0, NPIX, 0);
        idle(4);
        check_frame(1, NPIX);

        for (int i = 0; i < 9; i++) write_wt(i, (i == 4) ? 1 : 0);
        send_frame(2, 0, NPIX, 0);
        idle(4);
        check_frame(2, NPIX);
        s = 0;
        for (int k = 0; k < NPIX; k++) begin
            c = k - (IMG_W + 1);
            exp_bdr = 1;
            exp_pix = 0;
            if (c >= 0) begin
                if ((c / IMG_W >= 1) && (c / IMG_W <= IMG_H - 2) &&
                    (c % IMG_W >= 1) && (c % IMG_W <= IMG_W - 2)) begin
                    exp_bdr = 0;
                    exp_pix = (c / IMG_W) + (c % IMG_W);
                end
            end
            check($sformatf("ramp_pix_k%0d", k), cap_pix[k], exp_pix);
            check($sformatf("ramp_bdr_k%0d", k), cap_bdr[k], exp_bdr);
            s += cap_bdr[k];
            ref_pix[k] = cap_pix[k];
            ref_bdr[k] = cap_bdr[k];
        end
        check("ramp_border_count", s, 24);

        send_frame(2, 0, NPIX, 3);
        idle(4);
        check("gap_count", cap_n, NPIX);
        for (int k = 0; k < NPIX; k++) begin
            check($sformatf("gap_pix_k%0d", k), cap_pix[k], ref_pix[k]);
            check($sformatf("gap_bdr_k%0d", k), cap_bdr[k], ref_bdr[k]);
        end

        send_frame(2, 0, 20, 0);
        write_wt(4, 2);
        send_frame(2, 20, NPIX, 0);
        idle(4);
        check_frame(3, NPIX);

        bus.wt_we   = 1'b1;
        bus.wt_addr = 4'd4;
        bus.wt_data = WGT_W'(3);
        send_frame(2, 0, NPIX, 0);
        idle(4);
        check_frame(4, NPIX);

        send_frame(2, 0, NPIX, 0);
        idle(4);
        check_frame(5, NPIX);

        send_frame(2, 0, 20, 0);
        send_frame(2, 0, NPIX, 0);
        idle(4);
        check_frame(6, NPIX);
        for (int k = 0; k <= IMG_W; k++) begin
            check($sformatf("restart_pix_k%0d", k), cap_pix[k], 0);
            check($sformatf("restart_bdr_k%0d", k), cap_bdr[k], 1);
        end

        send_frame(2, 0, 29, 0);
        check("pre_reset_pix", int'(bus.pix_out), 9);
        rst = 1'b0;
        #1;
        check("midreset_out_valid", int'(bus.out_valid), 0);
        check("midreset_pix_out", int'(bus.pix_out), 0);
        check("midreset_out_border", int'(bus.out_border), 0);
        idle(2);
        rst = 1'b1;
        idle(5);
        send_frame(1, 0, NPIX, 0);
        idle(4);
        check_frame(7, NPIX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_window_engine.md
CONV_WINDOW_ENGINE -- requirements
Module: conv_window_engine

Interface
REQ-001 SHALL have parameter PIX_W, default 4, pixel bit width (unsigned).
REQ-002 SHALL have parameter IMG_W, default 640, pixels per row (≥4).
REQ-003 SHALL have parameter IMG_H, default 480, rows per frame (≥3).
REQ-004 SHALL have parameter WGT_W, default 5, signed kernel weight width.
REQ-005 SHALL have parameter SHIFT, default 0, arithmetic right shift applied to the sum before clamping.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port pix_in  input  PIX_W  raster-order input pixel.
REQ-009 SHALL have port pix_valid  input  1  pix_in accepted this cycle; may deassert for any number of cycles.
REQ-010 SHALL have port frame_start  input  1  qualifies pix_valid; marks pixel (0,0).
REQ-011 SHALL have port wt_we  input  1  shadow weight write strobe.
REQ-012 SHALL have port wt_addr  input  4  weight index 0-8 (0 = top-left, 4 = centre, 8 = bottom-right); 9-15 are ignored.
REQ-013 SHALL have port wt_data  input  WGT_W  signed weight value.
REQ-014 SHALL have port pix_out  output  PIX_W  filtered pixel.
REQ-015 SHALL have port out_valid  output  1  pix_out valid, one-cycle pulse.
REQ-016 SHALL have port out_border  output  1  pix_out is a forced-zero border or pre-image output.

Function
REQ-017 SHALL hold a 3x3 window and two line buffers of depth IMG_W; these shift only on cycles with pix_valid=1.
REQ-018 SHALL track column (0..IMG_W-1) and row (0..IMG_H-1) counters; column wraps to 0 and row increments after IMG_W-1; the row wraps to 0 after the last pixel of row IMG_H-1.
REQ-019 frame_start with pix_valid SHALL force the counters to (0,0) for that pixel, regardless of the current count.
REQ-020 SHALL emit exactly one output per accepted input; out_valid SHALL rise exactly 2 cycles after the accepting pix_valid cycle, independent of gaps.
REQ-021 Output k of a frame SHALL correspond to the centre at raster index k-(IMG_W+1).
REQ-022 If that centre index is negative, or the centre lies in row 0, row IMG_H-1, column 0 or column IMG_W-1, pix_out SHALL be 0 and out_border SHALL be 1.
REQ-023 Otherwise pix_out SHALL be the sum of w[i]*pixel[i] over the 9 window positions, with pixels zero-extended and treated as unsigned, and out_border SHALL be 0.
REQ-024 The accumulator SHALL be PIX_W+WGT_W+4 bits wide and signed; it SHALL never overflow.
REQ-025 After the accumulation the sum SHALL be shifted right arithmetically by SHIFT and then clamped: negative values give 0, values above 2^PIX_W-1 give 2^PIX_W-1.
REQ-026 wt_we SHALL write the shadow bank; the active bank SHALL copy the shadow bank on each frame_start acceptance, so weights never change mid-frame.
REQ-027 A write and a frame_start in the same cycle SHALL both take effect; the new write reaches the active bank at the next frame_start.

Reset
REQ-028 rst=0 SHALL asynchronously clear pix_out, out_valid, out_border, the counters, the window, the pipeline valids and the line buffers.
REQ-029 On reset the shadow and active weights SHALL load the edge kernel: -1 everywhere, 8 at index 4.
REQ-030 Reset mid-frame SHALL discard all in-flight outputs; no out_valid SHALL occur until 2 cycles after the first pix_valid following deassertion.

Configuration
REQ-031 Macro CONV_ABS_EN: when defined, the absolute value of the shifted sum SHALL be taken before clamping (edge magnitude).
REQ-032 Without CONV_ABS_EN, negative sums SHALL clamp to 0.

Verification (IMG_W=8, IMG_H=6, PIX_W=4, SHIFT=0)
REQ-033 Identity kernel (w4=1, others 0), ramp image pix=(r+c)&15 -> each interior output equals the centre pixel; the first 9 outputs and every border output are 0 with out_border=1.
REQ-034 Default edge kernel, flat image of 7 -> all interior outputs 0; single pixel 15 at (3,3) -> output at (3,3) is 15 (saturated), its neighbours are 0, and with CONV_ABS_EN its neighbours are 15.
REQ-035 pix_valid with random 0-3 cycle gaps -> output stream is identical to the gapless run, and every out_valid occurs 2 cycles after its input.
REQ-036 Write w4=2 mid-frame -> current frame is unchanged; next frame uses w4=2 from its first output.
REQ-037 rst low at row 3 col 5 -> outputs are 0 immediately; a new frame after release matches a clean run.
REQ-038 frame_start asserted early at row 2 -> counters restart, and the first IMG_W+1 outputs are border zeros.
